// File: rtl/msg_sequencer_if.sv
// ---------------------------------------------------------------------------
// msg_sequencer_if
// Byte-stream handshake between the message sequencer and a UART transmitter.
//   tx_data  : word currently presented by the source
//   tx_valid : tx_data holds a word to be sent
//   tx_ready : sink accepts the word on this cycle
// Modports: master = word source (sequencer), slave = word sink (UART TX).
// ---------------------------------------------------------------------------
interface msg_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/msg_sequencer.sv
// ---------------------------------------------------------------------------
// msg_sequencer
// Streams a runtime-loaded message buffer to a UART transmitter over a
// valid/ready handshake. One-shot or continuous repeat with an inter-pass
// gap, and an orderly stop that never withdraws a presented word.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   cfg_we_i/addr/wdata : buffer write port (honoured only while idle)
//   cfg_len_i        : message length in words (0..DEPTH, larger clamps)
//   start_i, stop_i  : single-cycle run control
//   repeat_en_i, gap_i : repeat mode and idle cycles between passes
//   tx_if            : word stream towards the UART (master side)
//   busy_o           : a run is in progress
//   done_o           : one-cycle pulse after each completed pass
//   byte_idx_o       : index of the word being presented
// ---------------------------------------------------------------------------
module msg_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int GAP_W  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LEN_W = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [AW-1:0]     cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic              start_i,
  input  logic              repeat_en_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic              stop_i,
  msg_sequencer_if.master   tx_if,
  output logic              busy_o,
  output logic              done_o,
  output logic [AW-1:0]     byte_idx_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              stop_pend_q;
  logic              valid_q;
  logic              done_q;

  logic              last_word;

  assign last_word = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_we_i && (32'(cfg_addr_i) < DEPTH)) begin
            mem_q[cfg_addr_i] <= cfg_wdata_i;
          end
          // stop on the same cycle as start cancels the request
          if (start_i && !stop_i && (cfg_len_i != '0)) begin
            len_q       <= (cfg_len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len_i;
            idx_q       <= '0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b1;
            state_q     <= SEND;
          end
        end

        SEND: begin
          if (tx_if.tx_ready) begin
            // a stop arriving on the accepting cycle counts as pending
            if (stop_pend_q || stop_i) begin
              idx_q       <= '0;
              stop_pend_q <= 1'b0;
              valid_q     <= 1'b0;
              state_q     <= IDLE;
            end else if (last_word) begin
              done_q <= 1'b1;
              idx_q  <= '0;
              if (!repeat_en_i) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
              end else if (gap_i != '0) begin
                gap_cnt_q <= gap_i;
                valid_q   <= 1'b0;
                state_q   <= GAP;
              end
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end else if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
        end

        GAP: begin
          if (stop_i) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (gap_cnt_q == GAP_W'(1)) begin
            gap_cnt_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b1;
            state_q   <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end

        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_if.tx_data  = mem_q[idx_q];
  assign tx_if.tx_valid = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign byte_idx_o     = idx_q;

endmodule

// File: tb/tb_msg_sequencer.sv
module tb_msg_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int GAP_W  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [DATA_W-1:0] cfg_wdata = '0;
  logic [AW:0]       cfg_len = '0;
  logic              start = 1'b0;
  logic              repeat_en = 1'b0;
  logic [GAP_W-1:0]  gap = '0;
  logic              stop = 1'b0;
  logic              busy;
  logic              done;
  logic [AW-1:0]     byte_idx;

  msg_sequencer_if #(.DATA_W(DATA_W)) tx_if ();

  msg_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .cfg_len_i  (cfg_len),
    .start_i    (start),
    .repeat_en_i(repeat_en),
    .gap_i      (gap),
    .stop_i     (stop),
    .tx_if      (tx_if),
    .busy_o     (busy),
    .done_o     (done),
    .byte_idx_o (byte_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic go(input logic [AW:0] len);
    cfg_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs the handshake until the block is idle with no done pulse.
  // rmode 0: tx_ready always 1; rmode 1: ready on every third cycle.
  task automatic stream(input string tag, input int rmode, input int limit,
                        output int nx, output int nd, output int nv);
    bit finished = 1'b0;
    nx = 0; nd = 0; nv = 0;
    for (int c = 0; c < limit; c++) begin
      tx_if.tx_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
      if (tx_if.tx_valid) begin
        nv++;
        chk({tag, "_data"}, 32'(tx_if.tx_data), 32'(model_mem[nx % DEPTH]));
        chk({tag, "_idx"}, 32'(byte_idx), 32'(nx % DEPTH));
        if (tx_if.tx_ready) begin
          $display("%s xfer %0d data %02h", tag, nx, tx_if.tx_data);
          nx++;
        end
      end
      if (done) nd++;
      if (!busy && !done && !tx_if.tx_valid) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_timeout"}, 32'(finished), 32'd1);
  endtask

  logic [DATA_W-1:0] msg [5];
  logic              rep_v [12];
  logic              rep_d [12];
  int nx, nd, nv;

  initial begin
    msg = '{8'h68, 8'h69, 8'h74, 8'h73, 8'h7A};
    rep_v = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    rep_d = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    tx_if.tx_ready = 1'b1;

    // reset state
    #12;
    chk("rst_valid", 32'(tx_if.tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(tx_if.tx_data), 0);
    chk("rst_idx", 32'(byte_idx), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) wr(AW'(i), msg[i]);

    // one-shot, ready always high
    go(5);
    chk("t1_first_valid", 32'(tx_if.tx_valid), 1);
    chk("t1_first_busy", 32'(busy), 1);
    stream("t1", 0, 40, nx, nd, nv);
    chk("t1_xfers", 32'(nx), 5);
    chk("t1_valid_cycles", 32'(nv), 5);
    chk("t1_dones", 32'(nd), 1);

    // one-shot, ready 1,0,0,1,...
    go(5);
    stream("t2", 1, 60, nx, nd, nv);
    chk("t2_xfers", 32'(nx), 5);
    chk("t2_valid_cycles", 32'(nv), 13);
    chk("t2_dones", 32'(nd), 1);

    // repeat, gap 3, two words
    tx_if.tx_ready = 1'b1;
    repeat_en = 1'b1; gap = 16'd3;
    go(2);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("t3_valid_c%0d", c), 32'(tx_if.tx_valid), 32'(rep_v[c]));
      chk($sformatf("t3_done_c%0d", c), 32'(done), 32'(rep_d[c]));
      if (rep_v[c]) begin
        chk($sformatf("t3_data_c%0d", c), 32'(tx_if.tx_data),
            32'((c % 5) == 0 ? 8'h68 : 8'h69));
        $display("t3 cycle %0d data %02h", c, tx_if.tx_data);
      end
      tick();
    end
    // now in the gap after the third pass; stop ends it in one edge
    chk("t3_gap_done", 32'(done), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat_en = 1'b0; gap = '0;
    chk("t3_stop_busy", 32'(busy), 0);
    chk("t3_stop_valid", 32'(tx_if.tx_valid), 0);
    chk("t3_stop_done", 32'(done), 0);

    // stop while word 2 of 5 is stalled
    go(5);
    chk("t4_w1_data", 32'(tx_if.tx_data), 32'h68);
    tick();
    tx_if.tx_ready = 1'b0; stop = 1'b1;
    chk("t4_w2_data", 32'(tx_if.tx_data), 32'h69);
    tick();
    stop = 1'b0;
    chk("t4_hold_valid", 32'(tx_if.tx_valid), 1);
    chk("t4_hold_data", 32'(tx_if.tx_data), 32'h69);
    tick();
    chk("t4_hold2_data", 32'(tx_if.tx_data), 32'h69);
    tx_if.tx_ready = 1'b1;
    $display("t4 xfer 1 data %02h with stop pending", tx_if.tx_data);
    tick();
    chk("t4_end_busy", 32'(busy), 0);
    chk("t4_end_valid", 32'(tx_if.tx_valid), 0);
    chk("t4_end_done", 32'(done), 0);
    tick();
    chk("t4_end_done2", 32'(done), 0);

    // zero length is ignored
    go(0);
    chk("t5_len0_busy", 32'(busy), 0);
    chk("t5_len0_valid", 32'(tx_if.tx_valid), 0);

    // oversized length clamps to DEPTH; a write during busy is dropped
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 8'(8'hA0 + i));
    tx_if.tx_ready = 1'b0;
    go(5'd31);
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 8'h55;
    tick();
    cfg_we = 1'b0;
    stream("t5", 0, 60, nx, nd, nv);
    chk("t5_xfers", 32'(nx), 16);
    chk("t5_dones", 32'(nd), 1);

    // asynchronous reset mid-message
    go(5);
    tick();
    tick();
    chk("t6_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_if.tx_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_data", 32'(tx_if.tx_data), 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    tick();
    chk("t6_rst_done_edge", 32'(done), 0);
    #3 rst_n = 1'b1;
    tick();
    go(5);
    stream("t6", 0, 40, nx, nd, nv);
    chk("t6_xfers", 32'(nx), 5);
    chk("t6_dones", 32'(nd), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_sequencer.md
# msg_sequencer

Parametrised byte-stream sequencer that replaces the fixed-content UART string selector. It holds a runtime-loadable message buffer of up to DEPTH words and streams a programmable-length message to the UART transmitter over a valid/ready handshake. It supports one-shot and continuous-repeat modes with a programmable inter-message gap, plus an orderly stop. It sits between the board control logic (buttons/switches or a host loader) and the UART TX block.

## Interface
- DATA_W, 8: width of each message word and of tx_data.
- DEPTH, 16: message buffer capacity in words; AW = clog2(DEPTH) is a derived localparam.
- GAP_W, 16: width of the inter-message gap counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  buffer write strobe.
- cfg_addr  in  AW  buffer write address.
- cfg_wdata  in  DATA_W  buffer write data.
- cfg_len  in  AW+1  message length in words, 0..DEPTH.
- start  in  1  single-cycle request to begin sending.
- repeat_en  in  1  1 = resend the message continuously.
- gap  in  GAP_W  idle cycles inserted between repeated passes.
- stop  in  1  single-cycle request to terminate.
- tx_data  out  DATA_W  current word, equal to mem[idx].
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at the end of each completed pass.
- byte_idx  out  AW  index of the word currently presented.

## Operation
- Buffer: DEPTH x DATA_W register array.
  - Written on cfg_we only in IDLE; writes while busy are ignored.
  - cfg_addr >= DEPTH is ignored.
- States: IDLE, SEND, GAP.
- IDLE:
  - start with cfg_len != 0 latches len = min(cfg_len, DEPTH), sets idx=0, and enters SEND.
  - start with cfg_len == 0 is ignored.
  - start and stop together: stop wins, and the block stays in IDLE.
- SEND:
  - tx_valid=1 and tx_data=mem[idx].
  - A transfer occurs on a cycle where tx_valid && tx_ready.
  - tx_data and idx hold while tx_ready=0.
- Transfer with idx < len-1: idx increments.
- Transfer with idx == len-1, when no stop is pending:
  - done pulses in the next cycle.
  - idx returns to 0.
  - If repeat_en=0, go to IDLE.
  - If repeat_en=1 and gap=0, stay in SEND (back-to-back passes).
  - If repeat_en=1 and gap>0, load the gap counter with gap and go to GAP.
  - repeat_en and gap are sampled on that final-transfer cycle.
- GAP: tx_valid=0. The counter decrements each cycle; on reaching 1, go to SEND with idx=0.
- stop:
  - In SEND it is recorded as pending. The current word is still held until its transfer, because tx_valid never drops before acceptance. On that transfer the block goes to IDLE with no done pulse, even if it was the last word.
  - In GAP, go to IDLE the next cycle.
  - In IDLE it is ignored.
- start while busy is ignored.
- len is fixed for the whole run; cfg_len changes while busy have no effect.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, tx_valid=0, busy=0, done=0, stop-pending=0, gap counter=0.
  - All buffer words = 0.
  - tx_data = mem[0] = 0.
- Start latency: start sampled at edge N gives tx_valid=1 and busy=1 after edge N, so the first word is presented in cycle N+1.
- Throughput: one word per cycle while tx_ready=1.
- done asserts for exactly one cycle after the edge that captured the last transfer.
  - One-shot: busy falls at that same edge.
  - Repeat with gap=G: tx_valid is low for exactly G cycles between the last transfer of one pass and the first word of the next.
- Stop latency:
  - GAP: one edge.
  - SEND: the edge of the pending word's transfer.
- Async reset mid-message aborts immediately; no done pulse.
- byte_idx and tx_data are combinational from registered idx and the buffer, so they are glitch-free relative to the clk edge.

## Test plan
- Load "hitsz" (68 69 74 73 7A) at addr 0-4, cfg_len=5, start, repeat_en=0, tx_ready=1 -> 5 consecutive tx_valid cycles with data 68,69,74,73,7A; done pulses once; busy low after the last transfer.
- Same message, tx_ready toggling 1,0,0,1,... -> each word is held stable while tx_ready=0, the sequence is unchanged, and exactly 5 transfers occur.
- repeat_en=1, gap=3, cfg_len=2 -> word pattern A,B, then 3 tx_valid-low cycles, then A,B, and so on; done pulses after each B.
- stop asserted while word 2 of 5 is stalled (tx_ready=0) -> word 2 stays valid until accepted, then IDLE; no done pulse; word 3 is never presented.
- cfg_len=0 start -> no activity; cfg_len=31 with DEPTH=16 -> exactly 16 words sent; cfg_we during busy -> buffer unchanged.
- rst_n pulled low mid-message -> tx_valid, busy and done are 0 immediately; buffer reads 0; after release, a new start sends the reset buffer contents.
